// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared state type and encodings for the end-of-test monitor.
package test_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    localparam logic [31:0] ECALL_ENC = 32'h0000_0073;
    localparam logic [4:0]  GP_IDX    = 5'd3;

endpackage

// File: rtl/test_monitor_if.sv
// test_monitor_if: retire and writeback streams from the core into the monitor.
interface test_monitor_if #(
    parameter int XLEN = 32
);
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ret_valid;
    logic [XLEN-1:0] ret_pc;
    logic [31:0]     ret_instr;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output ret_valid, ret_pc, ret_instr
    );

    modport slave (
        input wb_valid, wb_rd, wb_data,
        input ret_valid, ret_pc, ret_instr
    );
endinterface

// File: rtl/test_monitor_sat_counter.sv
// test_monitor_sat_counter (sat_counter): enabled up-counter that sticks at all-ones.
module test_monitor_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/test_monitor.sv
// test_monitor: shadows gp, detects ecall/HALT_PC completion, latches a sticky verdict.
// Define TEST_MONITOR_SIG_EN to add the rolling writeback signature output sig.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] HALT_PC        = 'h44,
    parameter int              TIMEOUT_CYCLES = 5000,
    parameter int              CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    test_monitor_if.slave    bus,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-2:0]  fail_testnum,
    output logic [XLEN-1:0]  gp_value,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
`ifdef TEST_MONITOR_SIG_EN
    ,
    output logic [XLEN-1:0]  sig
`endif
);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [XLEN-1:0]  GP_PASS  = XLEN'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_gp;
    logic [XLEN-1:0] w_gp_eff;
    logic [XLEN-2:0] r_testnum;
    logic            w_run;
    logic            w_gp_wr;
    logic            w_complete;
    logic            w_cyc_en;
    logic            w_ret_en;

    assign w_run      = (r_state == ST_RUN);
    assign w_gp_wr    = bus.wb_valid && (bus.wb_rd == GP_IDX);
    assign w_gp_eff   = w_gp_wr ? bus.wb_data : r_gp;
    assign w_complete = bus.ret_valid &&
                        ((bus.ret_instr == ECALL_ENC) ||
                         (bus.ret_pc == HALT_PC));

    // Completion is checked first so it wins over a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_complete) begin
                    w_state_nxt = (w_gp_eff == GP_PASS) ? ST_PASS : ST_FAIL;
                end else if (cycle_count == LAST_CYC) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // The timeout edge does not advance the cycle counter, leaving it at the last RUN cycle.
    assign w_cyc_en = w_run && (w_state_nxt != ST_TIMEOUT);
    assign w_ret_en = w_run && bus.ret_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_gp      <= '0;
            r_testnum <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_run && w_gp_wr) begin
                r_gp <= bus.wb_data;
            end
            if (w_run && (w_state_nxt == ST_FAIL)) begin
                r_testnum <= w_gp_eff[XLEN-1:1];
            end
        end
    end

    test_monitor_sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_cyc_en),
        .o_cnt (cycle_count)
    );

    test_monitor_sat_counter #(.CNT_W(CNT_W)) u_ret (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_ret_en),
        .o_cnt (retire_count)
    );

`ifdef TEST_MONITOR_SIG_EN
    logic [XLEN-1:0] r_sig;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sig <= '0;
        end else if (w_run && bus.wb_valid && (bus.wb_rd != 5'd0)) begin
            r_sig <= {r_sig[XLEN-2:0], r_sig[XLEN-1]} ^ bus.wb_data;
        end
    end

    assign sig = r_sig;
`endif

    assign done         = !w_run;
    assign pass         = (r_state == ST_PASS);
    assign fail         = (r_state == ST_FAIL);
    assign timeout      = (r_state == ST_TIMEOUT);
    assign fail_testnum = r_testnum;
    assign gp_value     = r_gp;
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: randomized and directed checks of test_monitor against a verdict model.
module tb_test_monitor;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] HALT  = 32'h0000_0044;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done, pass, fail, timeout;
    logic [30:0] fail_testnum;
    logic [31:0] gp_value;
    logic [31:0] cycle_count, retire_count;
`ifdef TEST_MONITOR_SIG_EN
    logic [31:0] sig;
`endif

    test_monitor_if #(.XLEN(32)) bus ();

    test_monitor #(
        .XLEN           (32),
        .HALT_PC        (32'h44),
        .TIMEOUT_CYCLES (5000),
        .CNT_W          (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_testnum (fail_testnum),
        .gp_value     (gp_value),
        .cycle_count  (cycle_count),
        .retire_count (retire_count)
`ifdef TEST_MONITOR_SIG_EN
        ,
        .sig          (sig)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: 0 running, 1 pass, 2 fail, 3 timeout
    int          m_st;
    logic [31:0] m_gp, m_cyc, m_ret, m_sig;
    logic [30:0] m_tn;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model_clear();
        m_st  = 0;
        m_gp  = '0;
        m_cyc = '0;
        m_ret = '0;
        m_sig = '0;
        m_tn  = '0;
    endtask

    task automatic idle_inputs();
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = '0;
        bus.ret_valid = 1'b0;
        bus.ret_pc    = '0;
        bus.ret_instr = '0;
    endtask

    // Apply one cycle of inputs, advance the model, and land 1ns after the edge.
    task automatic drive(input logic wbv, input logic [4:0] rd,
                         input logic [31:0] d, input logic rv,
                         input logic [31:0] pc, input logic [31:0] ins);
        logic [31:0] g;
        logic        c;
        bus.wb_valid  = wbv;
        bus.wb_rd     = rd;
        bus.wb_data   = d;
        bus.ret_valid = rv;
        bus.ret_pc    = pc;
        bus.ret_instr = ins;
        if (m_st == 0) begin
            g = (wbv && rd == 5'd3) ? d : m_gp;
            c = rv && (ins == ECALL || pc == HALT);
            if (wbv && rd != 5'd0) m_sig = {m_sig[30:0], m_sig[31]} ^ d;
            if (wbv && rd == 5'd3) m_gp = d;
            if (rv) m_ret = m_ret + 1;
            if (c) begin
                m_cyc = m_cyc + 1;
                if (g == 32'd1) begin
                    m_st = 1;
                end else begin
                    m_st = 2;
                    m_tn = g[31:1];
                end
            end else if (m_cyc == 32'd4999) begin
                m_st = 3;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic rand_idle(input int n);
        logic [31:0] r, pc, ins;
        for (int i = 0; i < n; i++) begin
            r   = $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            if (pc == HALT) pc = 32'h48;
            ins = $urandom | 32'h0000_1000;
            drive(r[5], r[4:0], $urandom, r[6], pc, ins);
        end
    endtask

    task automatic restart();
        idle_inputs();
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({done, pass, fail, timeout} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=0000", {done, pass, fail, timeout});
        end
        n_vec++;
        if (cycle_count !== 32'd0 || retire_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_count, retire_count);
        end
        n_vec++;
        if (gp_value !== 32'd0 || fail_testnum !== 31'd0) begin
            n_err++;
            $display("FAIL reset_gp got=%h/%h exp=0/0", gp_value, fail_testnum);
        end
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_pass();
        restart();
        rand_idle(20);
        drive(1'b1, 5'd3, 32'd1, 1'b0, 32'h3C, 32'h0000_0013);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, ECALL);
        n_vec++;
        if ({done, pass, fail, timeout} !== 4'b1100) begin
            n_err++;
            $display("FAIL pass_flags got=%b exp=1100", {done, pass, fail, timeout});
        end
        n_vec++;
        if (fail_testnum !== 31'd0) begin
            n_err++;
            $display("FAIL pass_testnum got=%0d exp=0", fail_testnum);
        end
        n_vec++;
        if (retire_count !== m_ret || cycle_count !== 32'd22) begin
            n_err++;
            $display("FAIL pass_counts got=%0d/%0d exp=%0d/22",
                     retire_count, cycle_count, m_ret);
        end
    endtask

    task automatic test_fail();
        restart();
        drive(1'b1, 5'd3, 32'h0000_000B, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 32'h100, ECALL);
        n_vec++;
        if ({done, pass, fail, timeout} !== 4'b1010) begin
            n_err++;
            $display("FAIL fail_flags got=%b exp=1010", {done, pass, fail, timeout});
        end
        n_vec++;
        if (fail_testnum !== 31'd5) begin
            n_err++;
            $display("FAIL fail_testnum got=%0d exp=5", fail_testnum);
        end
    endtask

    task automatic test_halt_pc();
        restart();
        drive(1'b1, 5'd3, 32'h0000_0015, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, HALT, 32'h0000_006F);
        n_vec++;
        if ({done, fail} !== 2'b11 || fail_testnum !== 31'd10) begin
            n_err++;
            $display("FAIL halt_pc got=%b/%0d exp=11/10", {done, fail}, fail_testnum);
        end
    endtask

    task automatic test_forward();
        restart();
        drive(1'b1, 5'd3, 32'd7, 1'b0, 32'h0, 32'h0);
        n_vec++;
        if (gp_value !== 32'd7) begin
            n_err++;
            $display("FAIL fwd_pre_gp got=%0d exp=7", gp_value);
        end
        drive(1'b1, 5'd3, 32'd1, 1'b1, 32'h40, ECALL);
        n_vec++;
        if ({done, pass, fail} !== 3'b110) begin
            n_err++;
            $display("FAIL fwd_flags got=%b exp=110", {done, pass, fail});
        end
    endtask

    task automatic test_freeze();
        drive(1'b1, 5'd3, 32'd9, 1'b1, 32'h40, ECALL);
        rand_idle(20);
        n_vec++;
        if (gp_value !== 32'd1 || gp_value !== m_gp) begin
            n_err++;
            $display("FAIL freeze_gp got=%0d exp=1", gp_value);
        end
        n_vec++;
        if ({done, pass, fail, timeout} !== 4'b1100) begin
            n_err++;
            $display("FAIL freeze_flags got=%b exp=1100", {done, pass, fail, timeout});
        end
        n_vec++;
        if (cycle_count !== m_cyc || retire_count !== m_ret) begin
            n_err++;
            $display("FAIL freeze_counts got=%0d/%0d exp=%0d/%0d",
                     cycle_count, retire_count, m_cyc, m_ret);
        end
    endtask

    task automatic test_ignore_rd();
        logic [31:0] v;
        restart();
        v = $urandom;
        drive(1'b1, 5'd3, v, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 5'd0, ~v, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 5'd5, v ^ 32'h55, 1'b0, 32'h0, 32'h0);
        n_vec++;
        if (gp_value !== v) begin
            n_err++;
            $display("FAIL ignore_rd got=%h exp=%h", gp_value, v);
        end
    endtask

    task automatic test_timeout();
        restart();
        rand_idle(4999);
        n_vec++;
        if (timeout !== 1'b0 || cycle_count !== 32'd4999) begin
            n_err++;
            $display("FAIL to_pre got=%b/%0d exp=0/4999", timeout, cycle_count);
        end
        rand_idle(1);
        n_vec++;
        if ({done, pass, fail, timeout} !== 4'b1001 || cycle_count !== 32'd4999) begin
            n_err++;
            $display("FAIL to_hit got=%b/%0d exp=1001/4999",
                     {done, pass, fail, timeout}, cycle_count);
        end
        drive(1'b1, 5'd3, 32'd1, 1'b1, 32'h40, ECALL);
        rand_idle(10);
        n_vec++;
        if ({pass, timeout} !== 2'b01 || cycle_count !== 32'd4999 ||
            retire_count !== m_ret || gp_value !== m_gp) begin
            n_err++;
            $display("FAIL to_frozen got=%b/%0d/%0d exp=01/4999/%0d",
                     {pass, timeout}, cycle_count, retire_count, m_ret);
        end
    endtask

    task automatic test_complete_at_last();
        restart();
        rand_idle(4998);
        drive(1'b1, 5'd3, 32'd1, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 32'h40, ECALL);
        n_vec++;
        if ({done, pass, fail, timeout} !== 4'b1100) begin
            n_err++;
            $display("FAIL last_cycle got=%b exp=1100", {done, pass, fail, timeout});
        end
        n_vec++;
        if (cycle_count !== 32'd5000) begin
            n_err++;
            $display("FAIL last_cycle_cnt got=%0d exp=5000", cycle_count);
        end
    endtask

    task automatic test_midrun_reset();
        restart();
        rand_idle(100);
        n_vec++;
        if (cycle_count !== 32'd100) begin
            n_err++;
            $display("FAIL mid_pre got=%0d exp=100", cycle_count);
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({done, pass, fail, timeout} !== 4'b0000 || cycle_count !== 32'd0 ||
            retire_count !== 32'd0 || gp_value !== 32'd0) begin
            n_err++;
            $display("FAIL mid_async got=%b/%0d/%0d/%h exp=0000/0/0/0",
                     {done, pass, fail, timeout}, cycle_count, retire_count, gp_value);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        rand_idle(10);
        n_vec++;
        if (cycle_count !== 32'd10 || retire_count !== m_ret) begin
            n_err++;
            $display("FAIL mid_restart got=%0d/%0d exp=10/%0d",
                     cycle_count, retire_count, m_ret);
        end
    endtask

    task automatic test_random();
        logic [31:0] g, r;
        for (int t = 0; t < 10; t++) begin
            restart();
            rand_idle($urandom_range(5, 60));
            r = $urandom;
            g = r[0] ? 32'd1 : $urandom;
            drive(1'b1, 5'd3, g, 1'b0, 32'h0, 32'h0);
            rand_idle($urandom_range(0, 5));
            if (r[1]) drive(1'b0, 5'd0, 32'd0, 1'b1, $urandom, ECALL);
            else      drive(r[2], r[7:3], $urandom, 1'b1, HALT, 32'h0000_1013);
            n_vec++;
            if ({pass, fail, timeout} !== {m_st == 1, m_st == 2, m_st == 3} ||
                done !== (m_st != 0)) begin
                n_err++;
                $display("FAIL rand_verdict t=%0d got=%b exp_state=%0d",
                         t, {done, pass, fail, timeout}, m_st);
            end
            n_vec++;
            if (fail_testnum !== m_tn || gp_value !== m_gp) begin
                n_err++;
                $display("FAIL rand_gp t=%0d got=%h/%h exp=%h/%h",
                         t, fail_testnum, gp_value, m_tn, m_gp);
            end
            n_vec++;
            if (cycle_count !== m_cyc || retire_count !== m_ret) begin
                n_err++;
                $display("FAIL rand_counts t=%0d got=%0d/%0d exp=%0d/%0d",
                         t, cycle_count, retire_count, m_cyc, m_ret);
            end
`ifdef TEST_MONITOR_SIG_EN
            n_vec++;
            if (sig !== m_sig) begin
                n_err++;
                $display("FAIL rand_sig t=%0d got=%h exp=%h", t, sig, m_sig);
            end
`endif
        end
    endtask

`ifdef TEST_MONITOR_SIG_EN
    task automatic test_sig();
        restart();
        drive(1'b1, 5'd1, 32'd1, 1'b0, 32'h0, 32'h0);
        n_vec++;
        if (sig !== 32'd1) begin
            n_err++;
            $display("FAIL sig_first got=%h exp=00000001", sig);
        end
        drive(1'b1, 5'd2, 32'd2, 1'b0, 32'h0, 32'h0);
        n_vec++;
        if (sig !== 32'd0) begin
            n_err++;
            $display("FAIL sig_second got=%h exp=00000000", sig);
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_pass();
        test_freeze();
        test_fail();
        test_halt_pc();
        test_forward();
        test_ignore_rd();
        test_midrun_reset();
        test_random();
        test_timeout();
        test_complete_at_last();
`ifdef TEST_MONITOR_SIG_EN
        test_sig();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/test_monitor.md
Name: test_monitor

Overview:
- Synthesizable end-of-test monitor placed directly downstream of the pipelined core.
- Consumes the core's retire and writeback streams and keeps a shadow of x3 (gp).
- Detects riscv-tests completion (ecall retire or HALT_PC retire) and latches a sticky pass/fail/timeout verdict with the failing test number.
- Replaces ad-hoc PC/register peeking in per-test benches; the bench only polls done/pass and writes the result file.

Parameters:
- XLEN, 32, data/PC width.
- HALT_PC, 32'h44, retiring this PC also ends the test.
- TIMEOUT_CYCLES, 5000, cycles in RUN before a timeout verdict.
- CNT_W, 32, width of the cycle and retire counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- wb_valid  in  1  register writeback this cycle.
- wb_rd  in  5  writeback destination index.
- wb_data  in  XLEN  writeback value.
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  XLEN  PC of the retiring instruction.
- ret_instr  in  32  encoding of the retiring instruction.
- done  out  1  verdict latched (sticky).
- pass  out  1  done with gp==1.
- fail  out  1  done with gp!=1.
- timeout  out  1  TIMEOUT_CYCLES reached without completion.
- fail_testnum  out  XLEN-1  gp>>1 latched at completion.
- gp_value  out  XLEN  current gp shadow.
- cycle_count  out  CNT_W  cycles spent in RUN.
- retire_count  out  CNT_W  instructions retired in RUN.

Behaviour:
- Reset (rst low, asynchronous): state=RUN. All outputs and counters are 0, and the gp shadow is 0.
- gp shadow: on wb_valid && wb_rd==3, gp <= wb_data. Writes to any other rd are ignored, including x0.
- Effective gp (gp_eff) is wb_data when a same-cycle write to x3 occurs, otherwise the registered gp. This is same-cycle forwarding.
- Completion event: ret_valid && (ret_instr==32'h0000_0073 || ret_pc==HALT_PC).
- FSM states: RUN, PASS, FAIL, TIMEOUT.
  - RUN -> PASS on a completion event with gp_eff==1.
  - RUN -> FAIL on a completion event with gp_eff!=1. Latch fail_testnum = gp_eff[XLEN-1:1].
  - RUN -> TIMEOUT when cycle_count == TIMEOUT_CYCLES-1 and there is no completion event that cycle.
  - PASS, FAIL and TIMEOUT are terminal and exit only on reset.
- Output latency: done, pass, fail and timeout are registered. They assert on the clock edge that ends the completion cycle (1-cycle latency).
- Output encoding: done = (state != RUN). pass, fail and timeout are one-hot and mutually exclusive.
- Counters in RUN:
  - cycle_count increments every cycle.
  - retire_count increments on ret_valid, including the completing instruction.
  - Both saturate at all-ones and do not wrap.
- Terminal states freeze the counters, gp shadow, fail_testnum and gp_value, so later wb/ret activity cannot alter the verdict.
- Simultaneous events: completion beats timeout in the same cycle. ecall and HALT_PC in the same instruction count as one event.
- Reset mid-run: state, counters and shadow clear immediately, with no partial verdict.

Optional Feature:
- Macro TEST_MONITOR_SIG_EN.
- When defined: adds output sig (XLEN).
  - Reset value 0.
  - In RUN, on each wb_valid with wb_rd!=0: sig <= {sig[XLEN-2:0], sig[XLEN-1]} ^ wb_data.
  - Frozen in terminal states.
  - Used for golden-signature comparison across core revisions.
- When undefined: the sig port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package test_monitor_pkg holds:
  - state typedef (RUN/PASS/FAIL/TIMEOUT);
  - ECALL_ENC = 32'h0000_0073;
  - GP_IDX = 5'd3.
- One natural sub-module: sat_counter (CNT_W, enable, saturating, async active-low clear). It is instantiated twice, for cycles and retires.

Test Plan:
- Write x3=1, then retire ecall at pc 0x40 -> next edge done=1, pass=1, fail=0, fail_testnum=0.
- Write x3=0x0000_000B, then retire ecall -> fail=1, fail_testnum=5, pass=0.
- Same cycle: wb x3=1 and ecall retire, with previous gp=7 -> pass=1 (forwarding).
- No completion for 5000 cycles -> timeout=1 at cycle_count=4999 frozen. A retire at cycle 4999 with ecall and gp=1 -> pass, not timeout.
- After PASS: wb x3=9 and another ecall -> gp_value, verdict and counters unchanged. Assert rst mid-run at cycle 100 -> all outputs 0 asynchronously, then run restarts.
- Writes to x0 and x5 -> gp unchanged. With TEST_MONITOR_SIG_EN: wb 1 then 2 -> sig=0x0000_0000.
